// File: rtl/tm1638_digit_encoder.sv
// Binary (0..MAX_VAL) to three TM1638 7-segment bytes via serial double-dabble.
// One shift per clock, then a lookup stage; outputs hold until the next result.
module tm1638_digit_encoder #(
  parameter int BIN_W    = 10,
  parameter int MAX_VAL  = 999,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic [7:0]       F,
  output logic [7:0]       S,
  output logic [7:0]       T
);

  localparam int CW = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, ENCODE} state_t;

  state_t           r_state, w_state_nx;
  logic             w_accept;
  logic [BIN_W-1:0] r_sh;
  logic [11:0]      r_bcd;
  logic [CW-1:0]    r_cnt;
  logic             r_ovf_n;
  logic [7:0]       r_f_n, r_s_n, r_t_n;
  logic             r_ovf_p, r_pub;
  logic             r_busy, r_done, r_ovf;
  logic [7:0]       r_f, r_s, r_t;
  logic [11:0]      w_adj;
  logic [7:0]       w_f, w_s, w_t;
  logic             w_ovf_in;

  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 8'hFC;
      4'd1:    seg7 = 8'h60;
      4'd2:    seg7 = 8'hDA;
      4'd3:    seg7 = 8'hF2;
      4'd4:    seg7 = 8'h66;
      4'd5:    seg7 = 8'hB6;
      4'd6:    seg7 = 8'hBE;
      4'd7:    seg7 = 8'hE0;
      4'd8:    seg7 = 8'hFE;
      4'd9:    seg7 = 8'hF6;
      default: seg7 = 8'h00;
    endcase
  endfunction

  function automatic logic [3:0] add3(input logic [3:0] n);
    add3 = (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  assign w_ovf_in = (32'(bin) > 32'(MAX_VAL));
  assign w_adj    = {add3(r_bcd[11:8]), add3(r_bcd[7:4]), add3(r_bcd[3:0])};

  always_comb begin
    w_f = seg7(r_bcd[11:8]);
    w_s = seg7(r_bcd[7:4]);
    w_t = seg7(r_bcd[3:0]);
    if (r_ovf_n) begin
      w_f = 8'h02;
      w_s = 8'h02;
      w_t = 8'h02;
    end else if (BLANK_LZ && r_bcd[11:8] == 4'd0) begin
      w_f = 8'h00;
      if (r_bcd[7:4] == 4'd0) w_s = 8'h00;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_accept   = 1'b0;
    case (r_state)
      IDLE: if (start) begin
        w_accept   = 1'b1;
        w_state_nx = SHIFT;
      end
      SHIFT:   if (r_cnt == CW'(BIN_W - 1)) w_state_nx = ENCODE;
      ENCODE:  w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nx;
  end

  // ENCODE stages the lookup; the publish edge that follows lands on IDLE,
  // so a held start is accepted on the same edge that raises done.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sh    <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
      r_ovf_n <= 1'b0;
      r_f_n   <= '0;
      r_s_n   <= '0;
      r_t_n   <= '0;
      r_ovf_p <= 1'b0;
      r_pub   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
      r_f     <= '0;
      r_s     <= '0;
      r_t     <= '0;
    end else begin
      r_pub  <= 1'b0;
      r_done <= r_pub;
      r_busy <= w_accept ? 1'b1 : (r_pub ? 1'b0 : r_busy);
      if (r_pub) begin
        r_f   <= r_f_n;
        r_s   <= r_s_n;
        r_t   <= r_t_n;
        r_ovf <= r_ovf_p;
      end
      case (r_state)
        IDLE: if (w_accept) begin
          r_sh    <= bin;
          r_bcd   <= '0;
          r_ovf_n <= w_ovf_in;
          r_cnt   <= '0;
        end
        SHIFT: begin
          r_bcd <= 12'({w_adj, r_sh[BIN_W-1]});
          r_sh  <= r_sh << 1;
          r_cnt <= r_cnt + CW'(1);
        end
        ENCODE: begin
          r_f_n   <= w_f;
          r_s_n   <= w_s;
          r_t_n   <= w_t;
          r_ovf_p <= r_ovf_n;
          r_pub   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign ovf  = r_ovf;
  assign F    = r_f;
  assign S    = r_s;
  assign T    = r_t;

endmodule

// File: tb/tb_tm1638_digit_encoder.sv
// Directed bench for tm1638_digit_encoder: two instances (blanking on/off) fed
// the same stimulus, checked against an arithmetic digit model via scoreboards.
module tb_tm1638_digit_encoder;

  localparam int BIN_W = 10;
  localparam int LAT   = BIN_W + 2;

  logic             clk = 1'b0;
  logic             rst, start;
  logic [BIN_W-1:0] bin;
  logic             busy, done, ovf, busy_z, done_z, ovf_z;
  logic [7:0]       F, S, T, F_z, S_z, T_z;

  typedef struct {
    logic [7:0] f, s, t;
    logic       o;
    int         acc;
  } exp_t;

  exp_t q1[$];
  exp_t q0[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  logic rst_q  = 1'b1;
  bit   mon_en = 1'b0;
  logic [24:0] prev1, prev0;
  logic [7:0]  lut [0:9] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66,
                             8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hF6};

  tm1638_digit_encoder #(.BIN_W(BIN_W), .MAX_VAL(999), .BLANK_LZ(1'b1)) u_dut (
    .clk(clk), .rst(rst), .start(start), .bin(bin),
    .busy(busy), .done(done), .ovf(ovf), .F(F), .S(S), .T(T));

  tm1638_digit_encoder #(.BIN_W(BIN_W), .MAX_VAL(999), .BLANK_LZ(1'b0)) u_dut_z (
    .clk(clk), .rst(rst), .start(start), .bin(bin),
    .busy(busy_z), .done(done_z), .ovf(ovf_z), .F(F_z), .S(S_z), .T(T_z));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input int v, input bit blank, input int acc);
    exp_t e;
    int h, tn, u;
    e.acc = acc;
    if (v > 999) begin
      e.f = 8'h02; e.s = 8'h02; e.t = 8'h02; e.o = 1'b1;
    end else begin
      h  = v / 100;
      tn = (v / 10) % 10;
      u  = v % 10;
      e.f = lut[h]; e.s = lut[tn]; e.t = lut[u]; e.o = 1'b0;
      if (blank && h == 0) begin
        e.f = 8'h00;
        if (tn == 0) e.s = 8'h00;
      end
    end
    return e;
  endfunction

  task automatic push(input int v, input int acc);
    q1.push_back(model(v, 1'b1, acc));
    q0.push_back(model(v, 1'b0, acc));
  endtask

  task automatic score(input bit which, input logic [7:0] f, input logic [7:0] s,
                       input logic [7:0] t, input logic o);
    exp_t  e;
    string id = which ? "lz1" : "lz0";
    int    n  = which ? q1.size() : q0.size();
    chk({id, "_pending_on_done"}, 32'(n != 0), 32'd1);
    if (n == 0) return;
    e = which ? q1.pop_front() : q0.pop_front();
    chk({id, "_F"}, 32'(f), 32'(e.f));
    chk({id, "_S"}, 32'(s), 32'(e.s));
    chk({id, "_T"}, 32'(t), 32'(e.t));
    chk({id, "_ovf"}, 32'(o), 32'(e.o));
    chk({id, "_latency"}, 32'(cyc), 32'(e.acc + LAT));
  endtask

  // Results must arrive only with done and stay frozen otherwise.
  always @(negedge clk) begin
    if (mon_en) begin
      if (done)   score(1'b1, F, S, T, ovf);
      else if (!rst_q) chk("lz1_hold", 32'({F, S, T, ovf}), 32'(prev1));
      if (done_z) score(1'b0, F_z, S_z, T_z, ovf_z);
      else if (!rst_q) chk("lz0_hold", 32'({F_z, S_z, T_z, ovf_z}), 32'(prev0));
    end
    prev1 <= {F, S, T, ovf};
    prev0 <= {F_z, S_z, T_z, ovf_z};
  end

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 3 * LAT) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_seen"}, 32'(done), 32'd1);
  endtask

  task automatic run(input int v);
    @(negedge clk);
    bin = BIN_W'(v); start = 1'b1;
    push(v, cyc + 1);
    @(negedge clk);
    start = 1'b0;
    bin   = BIN_W'($urandom);
    wait_done($sformatf("run%0d", v));
  endtask

  initial begin
    int a;
    rst = 1'b1; start = 1'b0; bin = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_FST", 32'({F, S, T}), 0);
    rst = 1'b0;
    mon_en = 1'b1;

    // 321 with busy profile over the whole conversion
    @(negedge clk);
    bin = 10'd321; start = 1'b1;
    a = cyc + 1;
    push(321, a);
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      chk($sformatf("busy_c%0d", k), 32'(busy), (k < LAT) ? 32'd1 : 32'd0);
      chk($sformatf("done_c%0d", k), 32'(done), (k == LAT) ? 32'd1 : 32'd0);
    end

    // Reset in the middle of SHIFT aborts the 321 request
    @(negedge clk);
    bin = 10'd321; start = 1'b1;
    a = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < a + 4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_ovf", 32'(ovf), 0);
    chk("abort_FST", 32'({F, S, T}), 0);
    rst = 1'b0;
    repeat (2 * LAT) @(negedge clk);

    run(7);
    run(1000);
    run(1023);
    run(999);
    foreach (lut[i]) if (i == 0) run(0);
    run(9);
    run(10);
    run(99);
    run(100);
    run(500);

    // start pulses while busy are dropped
    @(negedge clk);
    bin = 10'd123; start = 1'b1;
    a = cyc + 1;
    push(123, a);
    @(negedge clk);
    start = 1'b0;
    while (cyc < a + 2) @(negedge clk);
    bin = 10'd456; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < a + 7) @(negedge clk);
    bin = 10'd789; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("ignore");
    repeat (LAT + 4) @(negedge clk);

    // start held high: back-to-back conversions
    @(negedge clk);
    bin = 10'd42; start = 1'b1;
    a = cyc + 1;
    push(42, a);
    @(negedge clk);
    bin = 10'd256;
    push(256, a + LAT);
    while (cyc < a + LAT) @(negedge clk);
    bin = 10'd808;
    push(808, a + 2 * LAT);
    while (cyc < a + 2 * LAT) @(negedge clk);
    start = 1'b0;
    bin   = 10'd5;
    repeat (LAT + 4) @(negedge clk);

    chk("lz1_queue_drained", 32'(q1.size()), 0);
    chk("lz0_queue_drained", 32'(q0.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tm1638_digit_encoder.md
Name: tm1638_digit_encoder

Overview:
- Upstream feeder of the TM1638 display driver.
- Converts an unsigned binary value (0..999) to three 7-segment bytes: F = hundreds, S = tens, T = units. F is the leftmost digit.
- Uses iterative double-dabble, one bit per clock, then a segment lookup.
- Segment outputs are registered and held stable between conversions, so the driver can sample them at any time.

Parameters:
- BIN_W, 10, width of the binary input; it also sets the number of shift cycles.
- MAX_VAL, 999, largest value that can be displayed; any larger value is an overflow.
- BLANK_LZ, 1, 1 = blank leading zeros, 0 = show all three digits.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous reset, active-high.
- start  in  1  conversion request; sampled only in IDLE.
- bin  in  BIN_W  binary value; captured on the edge that accepts start.
- busy  out  1  high while a conversion is in progress.
- done  out  1  single-cycle pulse when F/S/T/ovf have been updated.
- ovf  out  1  registered flag: high when the last captured value was greater than MAX_VAL.
- F  out  8  hundreds segment byte.
- S  out  8  tens segment byte.
- T  out  8  units segment byte.

Behaviour:
- Reset: only clk and rst are fixed; rst is synchronous and active-high.
  - While rst=1 on a clock edge: state <= IDLE, busy=0, done=0, ovf=0, F=S=T=8'h00, and internal shift/BCD registers are cleared.
  - Reset mid-conversion aborts the conversion. No done pulse is produced and the outputs are cleared.
- Segment byte bit order, bit7..bit0 = a,b,c,d,e,f,g,dp. The dp bit is always 0.
  - Digits 0..9 map to FC,60,DA,F2,66,B6,BE,E0,FE,F6.
  - Blank = 00. Dash = 02 (segment g only).
- FSM states: IDLE, SHIFT, ENCODE.
  - IDLE: when start=1, capture bin into the shift register, clear the 12-bit BCD register, latch ovf_n = (bin > MAX_VAL), set busy=1, clear the counter, and go to SHIFT.
  - SHIFT: each cycle, first add 3 to any BCD nibble >= 5, then shift {bcd, shreg} left by 1. The counter increments each cycle. After BIN_W cycles go to ENCODE.
  - ENCODE: compute the segment bytes from the BCD nibbles. Register F/S/T and ovf, pulse done=1, drop busy=0, and return to IDLE.
- Latency: done goes high BIN_W+2 edges after the edge that sampled start; that is 12 cycles with the default parameters. F/S/T/ovf change only on that same edge.
- Overflow: conversion still runs for constant latency. Outputs become F=S=T=02 and ovf=1.
- Leading-zero blanking (BLANK_LZ=1, no overflow):
  - Hundreds = 0 → F=00.
  - Hundreds = 0 and tens = 0 → S=00.
  - T is never blanked.
  - With BLANK_LZ=0, all digits are encoded normally.
- start while busy: ignored. It is not queued and bin is not re-captured.
- start held high: one conversion per IDLE visit, i.e. back-to-back conversions every BIN_W+2 cycles. start seen in the cycle after done is accepted.
- Changes to bin during a conversion have no effect.
- Outputs hold their last values indefinitely while in IDLE.

Test Plan:
- Reset check: assert rst mid-SHIFT (cycle 5 after start=1 with bin=321) → next edge gives busy=0, F/S/T=00, ovf=0, and no done pulse ever appears for that request.
- bin=321, start pulse → done exactly 12 cycles later with F=F2, S=DA, T=60, ovf=0; busy high for cycles 1..11.
- bin=7, BLANK_LZ=1 → F=00, S=00, T=E0. The same value with BLANK_LZ=0 → F=FC, S=FC, T=E0.
- bin=1000, then bin=1023 → F=S=T=02, ovf=1, still 12-cycle latency. A following bin=999 → F=S=T=F6, ovf=0.
- Values 0, 9, 10, 99, 100, 500 in sequence:
  - 0 → 00,00,FC.
  - 9 → 00,00,F6.
  - 10 → 00,60,FC.
  - 99 → 00,F6,F6.
  - 100 → 60,FC,FC.
  - 500 → B6,FC,FC.
- Handshake:
  - Pulse start again at cycles 3 and 8 while busy, with different bin → ignored; the outputs reflect only the first value.
  - Hold start high continuously → a done pulse every 12 cycles, and F/S/T are stable between pulses.
